// File: rtl/pipe_issue_unit.sv
// Issue front end: buffers 24-bit instruction words in a small FIFO and issues them one per
// cycle to a forwarding-less pipeline, inserting bubbles on read-after-write hazards.
module pipe_issue_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HAZ_DEPTH  = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_word,
    output logic             issue_valid,
    output logic [3:0]       rs1,
    output logic [3:0]       rs2,
    output logic [3:0]       rd,
    output logic [3:0]       func,
    output logic [7:0]       addr,
    output logic             stall,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [23:0]         mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]       count_q;
    logic [HAZ_DEPTH-1:0] sb_valid_q;
    logic [3:0]          sb_rd_q [HAZ_DEPTH];

    logic        full, empty, hazard, do_push, do_pop;
    logic [23:0] head;

    assign full     = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign head     = mem_q[rd_ptr_q];

    // Both sources are checked against every live destination, regardless of func.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_valid_q[i] && (sb_rd_q[i] == head[15:12] || sb_rd_q[i] == head[11:8])) begin
                hazard = 1'b1;
            end
        end
        if (empty) begin
            hazard = 1'b0;
        end
    end

    assign do_push = in_valid && !full && !flush;
    assign do_pop  = !empty && !hazard && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sb_valid_q  <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                sb_rd_q[i] <= '0;
            end
            issue_valid <= 1'b0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            func        <= '0;
            addr        <= '0;
            stall       <= 1'b0;
            issued_cnt  <= '0;
            stall_cnt   <= '0;
        end else begin
            issue_valid <= 1'b0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            func        <= '0;
            addr        <= '0;
            stall       <= 1'b0;

            for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                sb_valid_q[i] <= sb_valid_q[i-1];
                sb_rd_q[i]    <= sb_rd_q[i-1];
            end
            sb_valid_q[0] <= 1'b0;
            sb_rd_q[0]    <= '0;

            if (flush) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                sb_valid_q <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr_q      <= rd_ptr_q + 1'b1;
                    issue_valid   <= 1'b1;
                    func          <= head[23:20];
                    rd            <= head[19:16];
                    rs1           <= head[15:12];
                    rs2           <= head[11:8];
                    addr          <= head[7:0];
                    sb_valid_q[0] <= 1'b1;
                    sb_rd_q[0]    <= head[19:16];
                    if (issued_cnt != '1) begin
                        issued_cnt <= issued_cnt + 1'b1;
                    end
                end
                if (hazard) begin
                    stall <= 1'b1;
                    if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                if (do_push && !do_pop) begin
                    count_q <= count_q + 1'b1;
                end else if (!do_push && do_pop) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_issue_unit.sv
// Scoreboard bench for pipe_issue_unit: a queue-based reference model predicts every cycle's
// outputs; a monitor pops predictions and compares them after each rising edge.
module tb_pipe_issue_unit;

    localparam int Depth    = 4;
    localparam int HazDepth = 2;
    localparam int CntW     = 5;
    localparam int CntMax   = (1 << CntW) - 1;
    localparam int RecW     = 27 + 2 * CntW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [23:0]     in_word = '0;
    logic            issue_valid;
    logic [3:0]      rs1, rs2, rd, func;
    logic [7:0]      addr;
    logic            stall;
    logic [CntW-1:0] issued_cnt, stall_cnt;

    pipe_issue_unit #(
        .FIFO_DEPTH(Depth),
        .HAZ_DEPTH (HazDepth),
        .CNT_W     (CntW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .issue_valid(issue_valid),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .func       (func),
        .addr       (addr),
        .stall      (stall),
        .issued_cnt (issued_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [RecW-1:0] exp_q[$];

    // Reference model: buffered words, recent issue history {valid, rd}, counters.
    logic [23:0] fq[$];
    logic [4:0]  hist[$];
    int          m_icnt, m_scnt;

    function automatic logic [23:0] mk(input int f, input int d, input int s1, input int s2,
                                       input int a);
        mk = {4'(f), 4'(d), 4'(s1), 4'(s2), 8'(a)};
    endfunction

    task automatic model_reset();
        fq.delete();
        hist.delete();
        for (int i = 0; i < HazDepth; i++) hist.push_back(5'd0);
        m_icnt = 0;
        m_scnt = 0;
    endtask

    task automatic step(input logic v, input logic [23:0] w, input logic fl, output bit acc);
        logic        iv, st, rdy, hz;
        logic [23:0] f;
        logic [4:0]  nw;
        @(negedge clk);
        in_valid = v;
        in_word  = w;
        flush    = fl;
        iv = 1'b0; st = 1'b0; f = '0; nw = '0; acc = 1'b0;
        if (fl) begin
            fq.delete();
            foreach (hist[i]) hist[i] = 5'd0;
        end else begin
            acc = v && (fq.size() < Depth);
            if (fq.size() > 0) begin
                hz = 1'b0;
                foreach (hist[i])
                    if (hist[i][4] && (hist[i][3:0] == fq[0][15:12] ||
                                       hist[i][3:0] == fq[0][11:8])) hz = 1'b1;
                if (hz) begin
                    st = 1'b1;
                    if (m_scnt < CntMax) m_scnt++;
                end else begin
                    f  = fq.pop_front();
                    iv = 1'b1;
                    nw = {1'b1, f[19:16]};
                    if (m_icnt < CntMax) m_icnt++;
                end
            end
            if (acc) fq.push_back(w);
        end
        hist.push_front(nw);
        void'(hist.pop_back());
        rdy = (fq.size() < Depth);
        exp_q.push_back({iv, f[15:12], f[11:8], f[19:16], f[23:20], f[7:0], st, rdy,
                         CntW'(m_icnt), CntW'(m_scnt)});
        cycle++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 24'd0, 1'b0, a);
    endtask

    task automatic push_word(input logic [23:0] w);
        bit a;
        int tries;
        tries = 0;
        do begin
            step(1'b1, w, 1'b0, a);
            tries++;
        end while (!a && tries < 50);
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL push_timeout word=%h never accepted (required acceptance)", w);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({issue_valid, rs1, rs2, rd, func, addr, stall, issued_cnt, stall_cnt} !== '0 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s got iv=%b rs1=%h rs2=%h rd=%h func=%h addr=%h stall=%b rdy=%b icnt=%0d scnt=%0d required all zero with rdy=1",
                     name, issue_valid, rs1, rs2, rd, func, addr, stall, in_ready, issued_cnt,
                     stall_cnt);
        end
    endtask

    // Monitor: the DUT presents a registered output every edge while out of reset.
    always @(posedge clk) begin
        logic [RecW-1:0] got, want;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {issue_valid, rs1, rs2, rd, func, addr, stall, in_ready, issued_cnt, stall_cnt};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL out t=%0t fields iv/rs1/rs2/rd/func/addr/stall/rdy/icnt/scnt got=%b/%h/%h/%h/%h/%h/%b/%b/%0d/%0d required=%b/%h/%h/%h/%h/%h/%b/%b/%0d/%0d",
                         $time, got[RecW-1], got[RecW-2 -: 4], got[RecW-6 -: 4], got[RecW-10 -: 4],
                         got[RecW-14 -: 4], got[RecW-18 -: 8], got[2*CntW+1], got[2*CntW],
                         got[2*CntW-1 -: CntW], got[CntW-1:0],
                         want[RecW-1], want[RecW-2 -: 4], want[RecW-6 -: 4], want[RecW-10 -: 4],
                         want[RecW-14 -: 4], want[RecW-18 -: 8], want[2*CntW+1], want[2*CntW],
                         want[2*CntW-1 -: CntW], want[CntW-1:0]);
            end
        end
    end

    initial begin
        bit a;
        model_reset();
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Single ADD: issues one edge after the push.
        push_word(mk(0, 10, 3, 5, 125));
        idle(3);

        // Back-to-back dependency: two bubbles before SUB.
        push_word(mk(0, 10, 3, 5, 125));
        push_word(mk(1, 14, 10, 5, 128));
        idle(5);

        // Dependency chain keeps the head stalled so the FIFO fills; extra words are refused.
        push_word(mk(0, 1, 8, 9, 1));
        step(1'b1, mk(1, 2, 1, 9, 2), 1'b0, a);
        step(1'b1, mk(1, 3, 2, 9, 3), 1'b0, a);
        step(1'b1, mk(1, 4, 3, 9, 4), 1'b0, a);
        step(1'b1, mk(1, 5, 4, 9, 5), 1'b0, a);
        step(1'b1, mk(1, 6, 5, 9, 6), 1'b0, a);
        step(1'b1, mk(1, 7, 6, 9, 7), 1'b0, a);
        step(1'b1, mk(1, 8, 7, 9, 8), 1'b0, a);
        idle(20);

        // Mixed stream with partial dependencies.
        push_word(mk(0, 10, 3, 5, 10));
        push_word(mk(2, 12, 6, 7, 20));
        push_word(mk(1, 14, 10, 5, 30));
        push_word(mk(3, 13, 8, 9, 40));
        push_word(mk(1, 15, 10, 5, 50));
        push_word(mk(0, 0, 12, 13, 60));
        idle(8);

        // Flush with three words buffered and a simultaneous push.
        push_word(mk(0, 1, 8, 9, 1));
        step(1'b1, mk(1, 2, 1, 9, 2), 1'b0, a);
        step(1'b1, mk(1, 3, 2, 9, 3), 1'b0, a);
        step(1'b1, mk(1, 4, 3, 9, 4), 1'b0, a);
        step(1'b1, mk(1, 5, 4, 9, 5), 1'b1, a);
        idle(1);
        push_word(mk(4, 6, 1, 2, 99));
        idle(3);

        // Randomised traffic with a narrow register range to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0,
                 mk($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 255)),
                 $urandom_range(0, 39) == 0, a);
        end
        idle(10);

        // Asynchronous reset between edges while an instruction is on the outputs.
        push_word(mk(0, 10, 3, 5, 77));
        idle(1);
        @(posedge clk);
        #3;
        checks++;
        if (issue_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_issue got issue_valid=%b required 1", issue_valid);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b1;
        push_word(mk(1, 14, 10, 5, 128));
        idle(3);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_predictions got %0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_issue_unit.md
Name: pipe_issue_unit

Overview:
- Upstream front end for the 4-stage register/ALU/memory pipeline.
- Accepts packed 24-bit instruction words over a valid/ready handshake and buffers them in a 4-entry FIFO.
- Decodes each word into the pipeline's rs1/rs2/rd/func/addr fields and issues at most one instruction per cycle.
- Inserts bubbles when a source register depends on a destination still in flight, because the pipeline has no forwarding.

Parameters:
- FIFO_DEPTH, 4, instruction buffer entries; must be a power of 2.
- HAZ_DEPTH, 2, issue slots a destination register stays blocked after issue.
- CNT_W, 16, width of the issued and stalled statistics counters.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of the FIFO and scoreboard.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  FIFO can accept a word.
- in_word  in  24  {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}.
- issue_valid  out  1  the fields below carry a real instruction this cycle.
- rs1  out  4  source register 1.
- rs2  out  4  source register 2.
- rd  out  4  destination register.
- func  out  4  ALU function code, passed through undecoded.
- addr  out  8  memory write address.
- stall  out  1  the head instruction was held this cycle due to a hazard.
- issued_cnt  out  CNT_W  instructions issued; saturating.
- stall_cnt  out  CNT_W  hazard-bubble cycles; saturating.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, scoreboard entries invalid, issue_valid=0, rs1/rs2/rd/func/addr=0, stall=0, counters=0, in_ready=1 after release.
- Reset mid-operation discards all buffered and in-flight state. No partial issue follows release.
- Push: in_valid && in_ready at the edge writes in_word at the tail.
- in_ready = !full. A full FIFO never accepts a word, even when a pop occurs in the same cycle.
- Pop and push in the same cycle are legal when the FIFO is neither full nor empty; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count is held in log2(FIFO_DEPTH)+1 bits.
- Scoreboard: HAZ_DEPTH-entry shift register of {valid, rd}.
  - Entry 0 holds the instruction currently on the output registers.
  - It shifts every cycle. A bubble shifts in valid=0.
- Hazard = FIFO not empty && (head.rs1 or head.rs2 equals rd of any valid scoreboard entry).
  - Both sources are always compared, whatever the func value.
- Each edge, all outputs registered:
  - Empty: bubble. issue_valid=0, fields=0, stall=0, no counter change.
  - Hazard: bubble. issue_valid=0, fields=0, stall=1, stall_cnt+1, head retained.
  - Otherwise: pop the head. issue_valid=1, fields = decoded head, stall=0, issued_cnt+1, {1,rd} shifts into scoreboard entry 0.
- Latency: a word pushed at edge k is issued at edge k+1 at the earliest.
- A dependent instruction issues no earlier than HAZ_DEPTH+1 edges after its producer, giving HAZ_DEPTH bubbles when back-to-back.
- rd equal to its own rs1/rs2 is not a hazard against itself.
- flush: empties the FIFO, invalidates the scoreboard and forces a bubble next edge (stall=0). Counters are retained.
  - flush overrides a simultaneous push; the word is dropped and in_ready is still reported.
- Counters saturate at all-ones and do not wrap.

Test Plan:
- Reset then push ADD {0,10,3,5,125} -> issue_valid=1 one edge later with rs1=3, rs2=5, rd=10, func=0, addr=125; issued_cnt=1.
- Push ADD rd=10 then SUB {1,14,10,5,128} back-to-back -> ADD issues, then 2 bubbles with stall=1, SUB issues on the 3rd edge after ADD; stall_cnt=2.
- Push 4 independent words with no pops possible (hold the head with a hazard) -> in_ready=0 after the 4th push; a 5th in_valid is not accepted and FIFO contents are unchanged.
- Push the 6-instruction stream ADD r10, MUL r12, SUB r14 (uses r10), SLA r13, SUB r15 (uses r10), ADD rd0 (uses r12, r13) -> issue order matches push order; bubbles appear only where a source matches a blocked rd.
- Assert flush with 3 words buffered and a push in the same cycle -> next edge issue_valid=0, FIFO empty, in_ready=1; a following independent word issues with no stall.
- Drop rst_n asynchronously between edges while issue_valid=1 -> all outputs go to 0 immediately; after release the first pushed word issues with no stall.
